wb_gpio_led: RTL



---
 rtl/wb_gpio_pkg.sv | 19 +
 rtl/wb_gpio_led_sync_edge.sv | 33 +++
 rtl/wb_gpio_led.sv | 133 +++++++++++++
 3 files changed

// File: rtl/wb_gpio_pkg.sv
// Shared constants for the Wishbone GPIO/LED slave: register word indices
// and the architectural register width.
package wb_gpio_pkg;

  localparam int REG_W = 8;

  localparam logic [2:0] REG_OUT   = 3'd0;
  localparam logic [2:0] REG_DIR   = 3'd1;
  localparam logic [2:0] REG_IN    = 3'd2;
  localparam logic [2:0] REG_LED   = 3'd3;
  localparam logic [2:0] REG_IEN   = 3'd4;
  localparam logic [2:0] REG_ISTAT = 3'd5;

  // Zero-extends an architectural register value onto the 32-bit data bus.
  function automatic logic [31:0] zext_reg(input logic [REG_W-1:0] v);
    return {{(32-REG_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/wb_gpio_led_sync_edge.sv
// Two-flop synchroniser for asynchronous pad inputs plus a third flop that
// flags rising edges of the synchronised value.
module gpio_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_s3;

  // Synchroniser chain and edge-history flop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/wb_gpio_led.sv
// Wishbone B3 classic slave driving the LED bank and the bidirectional IO
// header, with a rising-edge interrupt collected from the IO inputs.
module wb_gpio_led
  import wb_gpio_pkg::*;
#(
  parameter int                   GPIO_WIDTH = 8,
  parameter int                   LED_WIDTH  = 4,
  parameter logic [LED_WIDTH-1:0] LED_RESET  = '0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic [LED_WIDTH-1:0]  led_o,
  output logic                  irq_o
);

  logic [GPIO_WIDTH-1:0] r_out;
  logic [GPIO_WIDTH-1:0] r_dir;
  logic [GPIO_WIDTH-1:0] r_ien;
  logic [GPIO_WIDTH-1:0] r_istat;
  logic [LED_WIDTH-1:0]  r_led;
  logic                  r_ack;
  logic [31:0]           r_dat;
  logic                  r_irq;

  logic [GPIO_WIDTH-1:0] w_sync;
  logic [GPIO_WIDTH-1:0] w_edge;
  logic [GPIO_WIDTH-1:0] w_rise;
  logic [GPIO_WIDTH-1:0] w_clr;
  logic [GPIO_WIDTH-1:0] w_wgpio;
  logic [LED_WIDTH-1:0]  w_wled;
  logic [2:0]            w_idx;
  logic                  w_req;
  logic                  w_wr;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  gpio_sync_edge #(.WIDTH(GPIO_WIDTH)) u_sync (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n_i),
    .i_d     (gpio_i),
    .o_sync  (w_sync),
    .o_rise  (w_edge)
  );

  // The !ack term forces an idle cycle after every ack, so a held strobe is
  // never accepted twice.
  assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr    = w_req & wb_we_i & wb_sel_i[0];
  assign w_idx   = wb_adr_i[4:2];
  assign w_wgpio = wb_dat_i[GPIO_WIDTH-1:0];
  assign w_wled  = wb_dat_i[LED_WIDTH-1:0];
  assign w_rise  = w_edge & r_ien;

  assign w_unused = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i};

  // Write-1-to-clear mask for the interrupt status register
  always_comb begin
    w_clr = '0;
    if (w_wr && (w_idx == REG_ISTAT)) begin
      w_clr = w_wgpio;
    end else begin
      w_clr = '0;
    end
  end

  // Read-data mux; narrow registers zero-extend onto the bus
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_idx)
      REG_OUT:   w_rdata = zext_reg(REG_W'(r_out));
      REG_DIR:   w_rdata = zext_reg(REG_W'(r_dir));
      REG_IN:    w_rdata = zext_reg(REG_W'(w_sync));
      REG_LED:   w_rdata = zext_reg(REG_W'(r_led));
      REG_IEN:   w_rdata = zext_reg(REG_W'(r_ien));
      REG_ISTAT: w_rdata = zext_reg(REG_W'(r_istat));
      default:   w_rdata = 32'h0000_0000;
    endcase
  end

  // Control/status registers; set beats clear on ISTAT
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_out   <= '0;
      r_dir   <= '0;
      r_ien   <= '0;
      r_istat <= '0;
      r_led   <= LED_RESET;
    end else begin
      if (w_wr) begin
        case (w_idx)
          REG_OUT: r_out <= w_wgpio;
          REG_DIR: r_dir <= w_wgpio;
          REG_LED: r_led <= w_wled;
          REG_IEN: r_ien <= w_wgpio;
          default: ;
        endcase
      end
      r_istat <= (r_istat & ~w_clr) | w_rise;
    end
  end

  // Bus response and interrupt output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0000_0000;
      r_irq <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wb_we_i) ? w_rdata : 32'h0000_0000;
      r_irq <= |r_istat;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_irq;
  assign gpio_o   = r_out;
  assign gpio_oe  = r_dir;
  assign led_o    = r_led;

endmodule
